// File: rtl/mcdt_pkt_fmt.sv
// mcdt_pkt_fmt: buffers the mcdt word stream into three per-channel FIFOs
// and emits fixed-length packets (header + PKT_LEN payload words) from one
// channel at a time on a valid/ready stream, with round-robin channel choice.
module mcdt_pkt_fmt #(
    parameter int FIFO_DEPTH = 32,
    parameter int PKT_LEN    = 4
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [31:0] mcdt_data_i,
    input  logic        mcdt_val_i,
    input  logic [1:0]  mcdt_id_i,
    output logic [31:0] fmt_data_o,
    output logic        fmt_valid_o,
    input  logic        fmt_ready_i,
    output logic        fmt_sop_o,
    output logic        fmt_eop_o,
    output logic [1:0]  fmt_id_o,
    output logic [2:0]  ovf_o,
    output logic        bad_id_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] PLEN_C  = CW'(PKT_LEN);
    localparam logic [7:0]    PLEN8_C = 8'(PKT_LEN);
    localparam logic [7:0]    LAST_C  = 8'(PKT_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_HEAD, S_PAYLOAD} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              ch_q, ch_d;
    logic [1:0]              rr_q, rr_d;
    logic [7:0]              beat_q, beat_d;
    logic [2:0][7:0]         seq_q, seq_d;
    logic [2:0][CW-1:0]      cnt_q, cnt_d;
    logic [2:0][AW-1:0]      wptr_q, wptr_d;
    logic [2:0][AW-1:0]      rptr_q, rptr_d;
    logic [2:0]              elig_q, elig_d;
    logic [2:0]              ovf_q, ovf_d;
    logic                    bad_q, bad_d;
    logic [2:0]              push, pop;
    logic                    found;
    logic [1:0]              win;
    logic [31:0]             rd_word;
    logic [31:0]             mem_q [3][FIFO_DEPTH];

    // Capture side: full test uses the pre-pop count, so a same-cycle pop
    // never makes room. elig_q lags the count by one cycle, which gives the
    // two-edge push-to-header latency.
    always_comb begin
        push   = '0;
        pop    = '0;
        cnt_d  = cnt_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        ovf_d  = ovf_q;
        bad_d  = bad_q;
        elig_d = '0;
        for (int c = 0; c < 3; c++) begin
            if (mcdt_val_i && mcdt_id_i == 2'(c)) begin
                if (cnt_q[c] < DEPTH_C) push[c] = 1'b1;
                else                    ovf_d[c] = 1'b1;
            end
            pop[c] = (state_q == S_PAYLOAD) && fmt_ready_i && (ch_q == 2'(c));
            if (push[c]) wptr_d[c] = wptr_q[c] + 1'b1;
            if (pop[c])  rptr_d[c] = rptr_q[c] + 1'b1;
            case ({push[c], pop[c]})
                2'b10:   cnt_d[c] = cnt_q[c] + 1'b1;
                2'b01:   cnt_d[c] = cnt_q[c] - 1'b1;
                default: ;
            endcase
            elig_d[c] = (cnt_q[c] >= PLEN_C);
        end
        if (mcdt_val_i && mcdt_id_i == 2'd3) bad_d = 1'b1;
    end

    // Packet FSM: round-robin pick in IDLE, then header, then payload beats.
    // The live count is ANDed in so a stale elig_q right after a pop is ignored.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        rr_d    = rr_q;
        beat_d  = beat_q;
        seq_d   = seq_q;
        found   = 1'b0;
        win     = rr_q;
        for (int k = 1; k <= 3; k++) begin
            int idx;
            idx = (int'(rr_q) + k) % 3;
            if (!found && elig_q[idx] && cnt_q[idx] >= PLEN_C) begin
                found = 1'b1;
                win   = 2'(idx);
            end
        end
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    ch_d    = win;
                    rr_d    = win;
                    state_d = S_HEAD;
                end
            end
            S_HEAD: begin
                if (fmt_ready_i) begin
                    beat_d  = '0;
                    state_d = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (fmt_ready_i) begin
                    beat_d = beat_q + 8'd1;
                    if (beat_q == LAST_C) begin
                        seq_d[ch_q] = seq_q[ch_q] + 8'd1;
                        state_d     = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Head word of the active channel's FIFO.
    always_comb begin
        case (ch_q)
            2'd1:    rd_word = mem_q[1][rptr_q[1]];
            2'd2:    rd_word = mem_q[2][rptr_q[2]];
            default: rd_word = mem_q[0][rptr_q[0]];
        endcase
    end

    // Output decode from registered state only; stable while stalled.
    always_comb begin
        fmt_valid_o = (state_q == S_HEAD) || (state_q == S_PAYLOAD);
        fmt_sop_o   = (state_q == S_HEAD);
        fmt_eop_o   = (state_q == S_PAYLOAD) && (beat_q == LAST_C);
        fmt_id_o    = fmt_valid_o ? ch_q : 2'd0;
        fmt_data_o  = '0;
        if (state_q == S_HEAD)
            fmt_data_o = {8'hA5, 6'b0, ch_q, PLEN8_C, seq_q[ch_q]};
        else if (state_q == S_PAYLOAD)
            fmt_data_o = rd_word;
        ovf_o    = ovf_q;
        bad_id_o = bad_q;
    end

    // FIFO storage; pointers alone define contents, so no reset needed.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < 3; c++)
            if (push[c]) mem_q[c][wptr_q[c]] <= mcdt_data_i;
    end

    // Control state; reset abandons any packet and empties every FIFO.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            ch_q    <= 2'd0;
            rr_q    <= 2'd2;
            beat_q  <= '0;
            seq_q   <= '0;
            cnt_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            elig_q  <= '0;
            ovf_q   <= '0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            rr_q    <= rr_d;
            beat_q  <= beat_d;
            seq_q   <= seq_d;
            cnt_q   <= cnt_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            elig_q  <= elig_d;
            ovf_q   <= ovf_d;
            bad_q   <= bad_d;
        end
    end

endmodule

// File: tb/tb_mcdt_pkt_fmt.sv
// Directed bench for mcdt_pkt_fmt: accepted beats are collected at the
// falling edge into a queue and compared against hand-computed packets.
module tb_mcdt_pkt_fmt;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] mdata;
    logic        mval;
    logic [1:0]  mid;
    logic [31:0] fdata;
    logic        fvalid;
    logic        fready;
    logic        fsop;
    logic        feop;
    logic [1:0]  fid;
    logic [2:0]  ovf;
    logic        bad_id;

    always #5 clk = ~clk;

    mcdt_pkt_fmt #(.FIFO_DEPTH(32), .PKT_LEN(4)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .mcdt_data_i(mdata), .mcdt_val_i(mval), .mcdt_id_i(mid),
        .fmt_data_o(fdata), .fmt_valid_o(fvalid), .fmt_ready_i(fready),
        .fmt_sop_o(fsop), .fmt_eop_o(feop), .fmt_id_o(fid),
        .ovf_o(ovf), .bad_id_o(bad_id)
    );

    typedef struct {
        logic [31:0] d;
        logic        sop;
        logic        eop;
        logic [1:0]  id;
    } beat_t;

    beat_t mon_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, want);
        end
    endtask

    // Record accepted beats; check that a stalled word is held unchanged.
    logic        pv, pr;
    logic [31:0] pd;
    logic [3:0]  pf;
    always @(negedge clk) begin
        if (!rstn) begin
            pv <= 1'b0;
            pr <= 1'b0;
        end else begin
            if (pv && !pr) begin
                chk("hold_data", fdata, pd);
                chk("hold_flags", {27'b0, fvalid, fsop, feop, fid}, {27'b0, 1'b1, pf});
            end
            if (fvalid && fready) mon_q.push_back('{fdata, fsop, feop, fid});
            pv <= fvalid;
            pr <= fready;
            pd <= fdata;
            pf <= {fsop, feop, fid};
        end
    end

    task automatic do_reset();
        rstn   = 1'b0;
        mval   = 1'b0;
        mid    = 2'd0;
        mdata  = '0;
        fready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        mon_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] c, input logic [31:0] d);
        mval  = 1'b1;
        mid   = c;
        mdata = d;
        @(posedge clk);
        #1;
        mval = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        int t;
        t = 0;
        while (mon_q.size() < n && t < 3000) begin
            @(posedge clk);
            t++;
        end
        #1;
    endtask

    task automatic expect_pkt(input logic [1:0] c, input logic [7:0] s, input logic [31:0] base);
        beat_t b;
        wait_beats(5);
        chk("pkt_avail", 32'(mon_q.size() >= 5), 32'd1);
        if (mon_q.size() < 5) return;
        b = mon_q.pop_front();
        chk("hdr_data", b.d, {8'hA5, 6'b0, c, 8'h04, s});
        chk("hdr_flags", {28'b0, b.sop, b.eop, b.id}, {28'b0, 1'b1, 1'b0, c});
        for (int i = 0; i < 4; i++) begin
            b = mon_q.pop_front();
            chk("pay_data", b.d, base + 32'(i));
            chk("pay_flags", {28'b0, b.sop, b.eop, b.id}, {28'b0, 1'b0, (i == 3), c});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal;
    end

    initial begin
        // Reset state
        do_reset();
        chk("rst_valid", 32'(fvalid), 32'd0);
        chk("rst_data", fdata, 32'd0);
        chk("rst_flags", {28'b0, fsop, feop, fid}, 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_bad", 32'(bad_id), 32'd0);

        // Single channel, latency from last push to header
        fready = 1'b1;
        for (int i = 0; i < 4; i++) push(2'd0, 32'h00C0_0000 + 32'(i));
        @(negedge clk); chk("lat_n0", 32'(fvalid), 32'd0);
        @(negedge clk); chk("lat_n1", 32'(fvalid), 32'd0);
        @(negedge clk); chk("lat_n2", 32'(fvalid), 32'd1);
        chk("lat_hdr", fdata, 32'hA500_0400);
        expect_pkt(2'd0, 8'd0, 32'h00C0_0000);
        repeat (5) @(negedge clk);
        chk("single_idle", 32'(fvalid), 32'd0);
        chk("single_extra", 32'(mon_q.size()), 32'd0);

        // Round-robin across three channels, two packets each
        do_reset();
        for (int c = 0; c < 3; c++)
            for (int i = 0; i < 8; i++)
                push(2'(c), 32'h00C0_0000 + 32'(c) * 256 + 32'(i));
        fready = 1'b1;
        for (int s = 0; s < 2; s++)
            for (int c = 0; c < 3; c++)
                expect_pkt(2'(c), 8'(s), 32'h00C0_0000 + 32'(c) * 256 + 32'(4 * s));

        // Backpressure: ready alternates every cycle
        do_reset();
        for (int i = 0; i < 4; i++) push(2'd0, 32'h0000_00B0 + 32'(i));
        for (int k = 0; k < 30; k++) begin
            fready = (k % 2 == 0);
            @(posedge clk);
            #1;
        end
        fready = 1'b0;
        @(negedge clk);
        chk("bp_beats", 32'(mon_q.size()), 32'd5);
        expect_pkt(2'd0, 8'd0, 32'h0000_00B0);

        // Overflow: 33 words into channel 1 with output stalled
        do_reset();
        for (int i = 0; i < 33; i++) push(2'd1, 32'h1100_0000 + 32'(i));
        chk("ovf_flag", 32'(ovf), 32'h2);
        fready = 1'b1;
        for (int s = 0; s < 8; s++) expect_pkt(2'd1, 8'(s), 32'h1100_0000 + 32'(4 * s));
        repeat (10) @(negedge clk);
        chk("ovf_drain_q", 32'(mon_q.size()), 32'd0);
        chk("ovf_drain_v", 32'(fvalid), 32'd0);
        chk("ovf_sticky", 32'(ovf), 32'h2);

        // Illegal id, then seq wrap on channel 2
        do_reset();
        fready = 1'b1;
        push(2'd3, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("bad_id", 32'(bad_id), 32'd1);
        chk("bad_ovf", 32'(ovf), 32'd0);
        repeat (6) @(negedge clk);
        chk("bad_nopkt_v", 32'(fvalid), 32'd0);
        chk("bad_nopkt_q", 32'(mon_q.size()), 32'd0);
        @(posedge clk);
        #1;
        for (int p = 0; p < 257; p++) begin
            for (int i = 0; i < 4; i++) push(2'd2, 32'(p) * 4 + 32'(i));
            expect_pkt(2'd2, 8'(p), 32'(p) * 4);
        end
        chk("bad_sticky", 32'(bad_id), 32'd1);

        // Reset in the middle of a payload
        do_reset();
        for (int i = 0; i < 4; i++) push(2'd0, 32'h0000_00E0 + 32'(i));
        for (int t = 0; t < 20 && !fvalid; t++) @(negedge clk);
        chk("mid_head", 32'(fvalid), 32'd1);
        @(posedge clk);
        #1;
        fready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        fready = 1'b0;
        rstn   = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(fvalid), 32'd0);
        chk("mid_rst_data", fdata, 32'd0);
        chk("mid_rst_flags", {28'b0, fsop, feop, fid}, 32'd0);
        chk("mid_beats", 32'(mon_q.size()), 32'd3);
        @(negedge clk);
        rstn = 1'b1;
        mon_q.delete();
        fready = 1'b1;
        repeat (10) @(negedge clk);
        chk("mid_quiet_v", 32'(fvalid), 32'd0);
        chk("mid_quiet_q", 32'(mon_q.size()), 32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) push(2'd0, 32'h0000_00F0 + 32'(i));
        expect_pkt(2'd0, 8'd0, 32'h0000_00F0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mcdt_pkt_fmt.md
Name: mcdt_pkt_fmt

Overview:
- Downstream stage of the mcdt multi-channel arbiter.
- Captures the mcdt output word stream (data, valid, channel id) into three per-channel FIFOs.
- Assembles fixed-length packets of PKT_LEN words from a single channel, each prefixed by a header word.
- Emits packets on a valid/ready stream with SOP/EOP markers. The mcdt output has no backpressure, so input-side overflow is dropped and flagged.

Parameters:
- FIFO_DEPTH, 32, words per channel FIFO; power of 2, >= PKT_LEN.
- PKT_LEN, 4, payload words per packet; range 1..255.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rstn_i  input  1  asynchronous active-low reset.
- mcdt_data_i  input  32  data word from mcdt.
- mcdt_val_i  input  1  mcdt_data_i/mcdt_id_i valid this cycle.
- mcdt_id_i  input  2  source channel 0..2; 3 is illegal.
- fmt_data_o  output  32  packet word (header or payload).
- fmt_valid_o  output  1  fmt_data_o valid.
- fmt_ready_i  input  1  downstream accepts word when valid&&ready.
- fmt_sop_o  output  1  current word is the header.
- fmt_eop_o  output  1  current word is the last payload word.
- fmt_id_o  output  2  channel of the packet in flight.
- ovf_o  output  3  sticky per-channel overflow flags.
- bad_id_o  output  1  sticky: mcdt_val_i seen with id==3.

Behaviour:
- Reset (async assert, sync-release use):
  - fmt_data_o=0, fmt_valid_o=0, fmt_sop_o=0, fmt_eop_o=0, fmt_id_o=0, ovf_o=0, bad_id_o=0.
  - All FIFOs empty, all seq counters 0, FSM=IDLE, round-robin pointer=2 (channel 0 has first priority).
  - Reset mid-packet: the packet is abandoned and all buffered data is discarded.
- Capture, each cycle with mcdt_val_i=1:
  - id 0..2: if FIFO[id] count < FIFO_DEPTH, push mcdt_data_i.
  - Otherwise drop the word and set ovf_o[id].
  - The full test uses the count before any same-cycle pop. A pop in the same cycle does not make room.
  - id==3: word dropped, bad_id_o set.
  - Push and pop on the same FIFO in the same cycle are both performed; count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, HEAD, PAYLOAD.
- IDLE:
  - A channel is eligible when count >= PKT_LEN.
  - Round-robin pick: search starts at pointer+1, mod 3.
  - If any channel is eligible: latch ch=winner, pointer=winner, go to HEAD at the next edge.
  - fmt_valid_o=0 in IDLE.
  - Word pushed at edge N makes the channel eligible at N+1; header becomes valid after edge N+2.
- HEAD:
  - fmt_valid_o=1, fmt_sop_o=1, fmt_id_o=ch.
  - fmt_data_o = {8'hA5, 6'b0, ch[1:0], PKT_LEN[7:0], seq[ch][7:0]}.
  - On valid&&ready: go to PAYLOAD, beat=0.
- PAYLOAD:
  - fmt_valid_o=1, fmt_data_o=FIFO[ch] head, fmt_id_o=ch.
  - fmt_eop_o=1 when beat==PKT_LEN-1.
  - On valid&&ready: pop FIFO[ch], beat++.
  - On the accepted eop word: seq[ch]++ (wraps 255->0), go to IDLE.
  - No header is issued in the same cycle as EOP; there is at least one IDLE cycle between packets.
- Handshake: while fmt_valid_o=1 and fmt_ready_i=0, fmt_data_o/sop/eop/id hold stable. Valid never drops mid-packet.
- Payload data is never dropped once buffered. Only capture-side overflow loses data.
- Sticky flags clear only on reset.

Test Plan:
- Single channel: 4 words 0x00C0_0000..0x00C0_0003 on id 0, ready=1 -> header 0xA500_0400 then the 4 words in order; EOP on the 4th; header valid 2 cycles after the last push.
- Round-robin: 4 words each on ids 0,1,2 before any output, ready=1 -> packet order ch0, ch1, ch2; headers 0xA500_0400, 0xA501_0400, 0xA502_0400; pattern repeats 0,1,2 with 8 words per channel.
- Backpressure: ready toggles 1-0-1 every cycle during a packet -> every word held stable while ready=0; no duplicated or skipped words; exactly 5 accepted beats.
- Overflow: 33 words on id 1 with ready=0 -> first 32 buffered, 33rd dropped, ovf_o=3'b010; releasing ready yields 8 packets with seq 0..7 and 32 intact words.
- Illegal id / seq wrap: one beat with id=3 -> bad_id_o=1, no FIFO change; 257 packets on ch2 -> 257th header seq byte = 0x00.
- Reset mid-PAYLOAD after 2 beats -> all outputs 0 immediately; no packet emitted after release until 4 new words arrive; seq restarts at 0.
